dot_product_feeder: RTL and testbench
=====================================

Name: dot_product_feeder

Overview:
- Initiator-side sequencer for the NI-lane dot-product engine.
- Fetches two NOE-element single-precision vectors from element-wide memories and packs them into NI-element packages, zero-padding the tail.
- Releases the engine from reset and streams the packages with the engine's two-cycle half-split timing.
- Waits for the engine's finish, then captures the scalar result and returns it to the controller with a done pulse.

Parameters:
NOE, 10, number of elements per vector (>=1)
NI, 8, engine lane count (even, >=2); NPKG = ceil(NOE/NI) packages
ADDR_W, 8, memory address width (2**ADDR_W >= NOE)
TIMEOUT, 64, max cycles waited for dp_finish after the last package

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin one dot product (sampled only in IDLE)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when result is valid
error  out  1  one-cycle pulse on finish timeout
result  out  32  captured dot product (IEEE-754 single)
mem_rd_en  out  1  read strobe to both vector memories
mem_addr  out  ADDR_W  element index, shared by both memories
mem_a_rdata  in  32  vector A element, valid 1 cycle after mem_rd_en
mem_b_rdata  in  32  vector B element, valid 1 cycle after mem_rd_en
dp_reset  out  1  engine reset
dp_row_a  out  32*NI  engine first-row package
dp_row_b  out  32*NI  engine second-row package
dp_finish  in  1  engine finish (level; engine holds it high until reset)
dp_result  in  32  engine dot_product_output

Behaviour:
- Reset values: busy=0, done=0, error=0, result=0, mem_rd_en=0, mem_addr=0, dp_reset=1, dp_row_a=dp_row_b=0. State = IDLE, package buffer cleared.
- dp_reset is 1 in IDLE, LOAD, DONE and ERR. It is 0 only in STREAM and DRAIN.
- Packing: element k goes to package p=k/NI, slot s=k%NI. Slot 0 is the most significant 32 bits, [32*NI-1 -: 32]; the engine consumes the upper half first. Slots with k>=NOE are 0x00000000.
- IDLE: when start=1, clear the buffer and go to LOAD.
  - start while busy is ignored; no queuing.
- LOAD: mem_rd_en=1 with mem_addr=0..NOE-1 on consecutive cycles.
  - Read data for address k is written into slot k one cycle later.
  - After the last element is captured, go to STREAM. LOAD lasts NOE+1 cycles.
- STREAM: dp_reset=0. Package p drives dp_row_a/b for exactly 2 cycles, starting with p=0 on the first STREAM cycle and advancing in order through NPKG-1. STREAM lasts 2*NPKG cycles, then go to DRAIN.
  - Rows change only on even cycle offsets within STREAM.
- DRAIN: rows driven to 0 and dp_reset held 0. A cycle counter starts at 0.
  - dp_finish=1: result <= dp_result, go to DONE.
  - Counter reaches TIMEOUT-1 without finish: go to ERR.
  - If dp_finish is 1 in the same cycle as the timeout compare, finish wins.
- DONE: done=1 for one cycle, then IDLE. result holds until the next successful capture.
- ERR: error=1 for one cycle, then IDLE. result unchanged.
- dp_finish is ignored outside DRAIN, including any stale level in the first STREAM cycle.
- reset asserted in any state: next cycle all outputs at reset values and any in-flight read data is discarded. No done or error pulse is issued for an aborted run.
- NOE an exact multiple of NI: no padding, NPKG = NOE/NI.
- Total latency, start to done: 1 (IDLE->LOAD) + NOE+1 + 2*NPKG + DRAIN wait + 1 cycles.

Test Plan:
- Pack/pad, NOE=10, NI=8: A[k]=0x3F800000+k, B[k]=0x40000000+k. Required response:
  - Package 0 slot 0 = 0x3F800000, slot 7 = 0x3F800007.
  - Package 1 slots 0,1 = 0x3F800008/9; slots 2..7 = 0.
  - Same layout for B.
- Stream timing: with a behavioral engine asserting finish 12 cycles into DRAIN → dp_reset low for exactly 4+12 cycles; each package is stable for exactly 2 cycles; rows are 0 in DRAIN.
- Result capture: A all 1.0 (0x3F800000), B all 2.0 (0x40000000), engine model returns 0x41A00000 → result=0x41A00000, done one cycle, busy falls the following cycle.
- Timeout: dp_finish never asserted → error pulses after exactly 64 DRAIN cycles, done never asserts, result keeps its prior value.
- Reset mid-STREAM (package 1, cycle 1) → next cycle dp_reset=1, rows=0, busy=0. A fresh start then completes a full correct run.
- start held high through a run, plus NOE=16 (no padding) → exactly one run per IDLE entry; 2 packages with no zero slots.

Source files
------------

// File: rtl/dot_product_feeder_if.sv
// Memory-read and dot-product-engine bus between the feeder and its peers.
// master is the feeder side; slave is the memories plus engine side.
interface dot_product_feeder_if #(
    parameter int ADDR_W = 8,
    parameter int NI     = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_a_rdata;
    logic [31:0]       mem_b_rdata;
    logic              dp_reset;
    logic [32*NI-1:0]  dp_row_a;
    logic [32*NI-1:0]  dp_row_b;
    logic              dp_finish;
    logic [31:0]       dp_result;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_a_rdata, mem_b_rdata,
        output dp_reset, dp_row_a, dp_row_b,
        input  dp_finish, dp_result
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_a_rdata, mem_b_rdata,
        input  dp_reset, dp_row_a, dp_row_b,
        output dp_finish, dp_result
    );
endinterface

// File: rtl/dot_product_feeder.sv
// Fetches two vectors, packs them into NI-lane packages and streams them
// into the dot-product engine, then returns the engine's scalar result.
module dot_product_feeder #(
    parameter int NOE     = 10,
    parameter int NI      = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    dot_product_feeder_if.master bus
);
    localparam int NPKG  = (NOE + NI - 1) / NI;
    localparam int NSLOT = NPKG * NI;
    localparam int RW    = 32 * NI;
    localparam int CMAX  = (2 * NPKG > TIMEOUT) ? 2 * NPKG : TIMEOUT;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       result_q, result_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cap_vld_q, cap_vld_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
    logic              dp_reset_q, dp_reset_d;
    logic [RW-1:0]     row_a_q, row_a_d;
    logic [RW-1:0]     row_b_q, row_b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       buf_a_q [NSLOT];
    logic [31:0]       buf_a_d [NSLOT];
    logic [31:0]       buf_b_q [NSLOT];
    logic [31:0]       buf_b_d [NSLOT];
    logic              row_en;
    logic [CW-1:0]     pkg_sel;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        result_d  = result_q;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        cap_vld_d = rd_en_q;
        cap_idx_d = addr_q;
        cnt_d     = cnt_q;
        row_en    = 1'b0;
        pkg_sel   = '0;
        row_a_d   = '0;
        row_b_d   = '0;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;

        // Read data lands one cycle after its strobe
        for (int k = 0; k < NSLOT; k++) begin
            if (cap_vld_q && 32'(cap_idx_q) == k) begin
                buf_a_d[k] = bus.mem_a_rdata;
                buf_b_d[k] = bus.mem_b_rdata;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    for (int k = 0; k < NSLOT; k++) begin
                        buf_a_d[k] = '0;
                        buf_b_d[k] = '0;
                    end
                end
            end
            S_LOAD: begin
                if (rd_en_q && addr_q != ADDR_W'(NOE - 1)) begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
                if (cap_vld_q && cap_idx_q == ADDR_W'(NOE - 1)) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                    row_en  = 1'b1;
                end
            end
            S_STREAM: begin
                if (cnt_q == CW'(2 * NPKG - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    row_en  = 1'b1;
                    pkg_sel = cnt_d >> 1;
                end
            end
            S_DRAIN: begin
                if (bus.dp_finish) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = bus.dp_result;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Slot 0 sits in the top word; the engine eats the upper half first
        if (row_en) begin
            for (int p = 0; p < NPKG; p++) begin
                if (pkg_sel == CW'(p)) begin
                    for (int s = 0; s < NI; s++) begin
                        row_a_d[RW-1-32*s -: 32] = buf_a_d[p*NI+s];
                        row_b_d[RW-1-32*s -: 32] = buf_b_d[p*NI+s];
                    end
                end
            end
        end

        dp_reset_d = !(state_d == S_STREAM || state_d == S_DRAIN);
        busy_d     = state_d != S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            dp_reset_q <= 1'b1;
            row_a_q    <= '0;
            row_b_q    <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                buf_a_q[k] <= '0;
                buf_b_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            result_q   <= result_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            dp_reset_q <= dp_reset_d;
            row_a_q    <= row_a_d;
            row_b_q    <= row_b_d;
            cnt_q      <= cnt_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign result       = result_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.dp_reset  = dp_reset_q;
    assign bus.dp_row_a  = row_a_q;
    assign bus.dp_row_b  = row_b_q;
endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: two instances (padded NOE=10, unpadded
// NOE=16) against shared vector memories and a behavioural engine.
module tb_dot_product_feeder;
    localparam int NI = 8;
    localparam int AW = 8;
    localparam int TO = 64;
    localparam int N0 = 10;
    localparam int P0 = 2;
    localparam int N1 = 16;
    localparam int P1 = 2;
    localparam int RW = 32 * NI;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset  = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        busy0, done0, error0;
    logic        busy1, done1, error1;
    logic [31:0] result0, result1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0]   mem_a [256];
    logic [31:0]   mem_b [256];
    int            thr0 = 100000;
    int            thr1 = 100000;
    int            low0 = 0;
    int            low1 = 0;
    logic [31:0]   res0 = '0;
    logic [31:0]   res1 = '0;
    logic [RW-1:0] seen_a [2];
    logic [RW-1:0] seen_b [2];

    dot_product_feeder_if #(.ADDR_W(AW), .NI(NI)) bus0 ();
    dot_product_feeder_if #(.ADDR_W(AW), .NI(NI)) bus1 ();

    dot_product_feeder #(.NOE(N0), .NI(NI), .ADDR_W(AW), .TIMEOUT(TO)) u0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0),
        .done(done0), .error(error0), .result(result0), .bus(bus0)
    );

    dot_product_feeder #(.NOE(N1), .NI(NI), .ADDR_W(AW), .TIMEOUT(TO)) u1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1),
        .done(done1), .error(error1), .result(result1), .bus(bus1)
    );

    // Memories answer one cycle after the strobe; engine finishes after
    // thrN cycles of being out of reset and holds finish until reset.
    always @(posedge clk) begin
        if (bus0.mem_rd_en) begin
            bus0.mem_a_rdata <= mem_a[bus0.mem_addr];
            bus0.mem_b_rdata <= mem_b[bus0.mem_addr];
        end
        if (bus1.mem_rd_en) begin
            bus1.mem_a_rdata <= mem_a[bus1.mem_addr];
            bus1.mem_b_rdata <= mem_b[bus1.mem_addr];
        end
        low0 <= bus0.dp_reset ? 0 : low0 + 1;
        low1 <= bus1.dp_reset ? 0 : low1 + 1;
    end

    assign bus0.dp_finish = !bus0.dp_reset && (low0 >= thr0);
    assign bus1.dp_finish = !bus1.dp_reset && (low1 >= thr1);
    assign bus0.dp_result = res0;
    assign bus1.dp_result = res1;

    function automatic logic [RW-1:0] exp_row(int noe, int p, bit is_b);
        logic [RW-1:0] r;
        r = '0;
        for (int s = 0; s < NI; s++) begin
            int k;
            k = p * NI + s;
            if (k < noe) r[RW-1-32*s -: 32] = is_b ? mem_b[k] : mem_a[k];
        end
        return r;
    endfunction

    task automatic fill_rand();
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = $urandom | 32'h1;
            mem_b[k] = $urandom | 32'h1;
        end
    endtask

    // One full run of u0, checked cycle by cycle against the phase timeline
    task automatic run0(input bit to);
        int w, s0, d, lows;
        logic [31:0]   prev, eres;
        logic [4:0]    got, exp;
        logic [RW-1:0] ea, eb;
        w    = to ? TO : ((thr0 > 2 * P0) ? thr0 - 2 * P0 : 0) + 1;
        s0   = N0 + 1;
        d    = s0 + 2 * P0 + w;
        prev = result0;
        eres = to ? prev : res0;
        lows = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int j = 0; j <= d + 1; j++) begin
            ea = '0;
            eb = '0;
            if (j >= s0 && j < s0 + 2 * P0) begin
                ea = exp_row(N0, (j - s0) / 2, 1'b0);
                eb = exp_row(N0, (j - s0) / 2, 1'b1);
            end
            exp = {j < N0, !(j >= s0 && j < d), !to && j == d,
                   to && j == d, j <= d};
            got = {bus0.mem_rd_en, bus0.dp_reset, done0, error0, busy0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ctl j=%0d rd/rst/done/err/busy got %b exp %b",
                         j, got, exp);
            end
            if (j < N0) begin
                n_chk++;
                if (bus0.mem_addr !== AW'(j)) begin
                    n_fail++;
                    $display("FAIL addr j=%0d got %0d exp %0d",
                             j, bus0.mem_addr, j);
                end
            end
            n_chk++;
            if (bus0.dp_row_a !== ea || bus0.dp_row_b !== eb) begin
                n_fail++;
                $display("FAIL rows j=%0d got a=%h exp a=%h", j,
                         bus0.dp_row_a, ea);
            end
            if (j == s0) begin
                seen_a[0] = bus0.dp_row_a;
                seen_b[0] = bus0.dp_row_b;
            end
            if (j == s0 + 2) begin
                seen_a[1] = bus0.dp_row_a;
                seen_b[1] = bus0.dp_row_b;
            end
            if (!bus0.dp_reset) lows++;
            @(negedge clk);
        end
        n_chk++;
        if (lows != 2 * P0 + w) begin
            n_fail++;
            $display("FAIL dp_reset_low got %0d exp %0d", lows, 2 * P0 + w);
        end
        n_chk++;
        if (result0 !== eres) begin
            n_fail++;
            $display("FAIL result got %h exp %h", result0, eres);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy0, done0, error0, bus0.mem_rd_en, bus0.dp_reset} !== 5'b00001
            || result0 !== '0 || bus0.mem_addr !== '0
            || bus0.dp_row_a !== '0 || bus0.dp_row_b !== '0) begin
            n_fail++;
            $display("FAIL reset0 got busy=%b rst=%b res=%h exp 0/1/0",
                     busy0, bus0.dp_reset, result0);
        end
        n_chk++;
        if ({busy1, done1, error1, bus1.mem_rd_en, bus1.dp_reset} !== 5'b00001
            || result1 !== '0 || bus1.dp_row_a !== '0) begin
            n_fail++;
            $display("FAIL reset1 got busy=%b rst=%b res=%h exp 0/1/0",
                     busy1, bus1.dp_reset, result1);
        end
        reset = 1'b0;
    endtask

    task automatic test_pack_pad();
        logic [RW-1:0] r;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 32'h3F800000 + k;
            mem_b[k] = 32'h40000000 + k;
        end
        thr0 = 2 * P0 + 2;
        res0 = $urandom;
        run0(1'b0);
        r = seen_a[0];
        n_chk++;
        if (r[RW-1 -: 32] !== 32'h3F800000 || r[31:0] !== 32'h3F800007) begin
            n_fail++;
            $display("FAIL pack_a0 got %h exp 3f800000..3f800007", r);
        end
        r = seen_a[1];
        n_chk++;
        if (r[RW-1 -: 32] !== 32'h3F800008 || r[RW-33 -: 32] !== 32'h3F800009
            || r[RW-65:0] !== '0) begin
            n_fail++;
            $display("FAIL pad_a1 got %h exp 3f800008 3f800009 then 0", r);
        end
        r = seen_b[0];
        n_chk++;
        if (r[RW-1 -: 32] !== 32'h40000000 || r[31:0] !== 32'h40000007) begin
            n_fail++;
            $display("FAIL pack_b0 got %h exp 40000000..40000007", r);
        end
        r = seen_b[1];
        n_chk++;
        if (r[RW-1 -: 32] !== 32'h40000008 || r[RW-33 -: 32] !== 32'h40000009
            || r[RW-65:0] !== '0) begin
            n_fail++;
            $display("FAIL pad_b1 got %h exp 40000008 40000009 then 0", r);
        end
    endtask

    task automatic test_stream_timing();
        fill_rand();
        thr0 = 2 * P0 + 11;
        res0 = $urandom;
        run0(1'b0);
    endtask

    task automatic test_result_capture();
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 32'h3F800000;
            mem_b[k] = 32'h40000000;
        end
        res0 = 32'h41A00000;
        thr0 = $urandom_range(2 * P0 + 20, 2 * P0);
        run0(1'b0);
        n_chk++;
        if (result0 !== 32'h41A00000) begin
            n_fail++;
            $display("FAIL capture got %h exp 41a00000", result0);
        end
    endtask

    task automatic test_timeout();
        fill_rand();
        thr0 = 100000;
        res0 = 32'hDEADBEEF;
        run0(1'b1);
        n_chk++;
        if (result0 !== 32'h41A00000) begin
            n_fail++;
            $display("FAIL timeout_hold got %h exp 41a00000", result0);
        end
    endtask

    task automatic test_stale_finish();
        fill_rand();
        thr0 = 0;
        res0 = $urandom;
        run0(1'b0);
    endtask

    task automatic test_reset_mid();
        fill_rand();
        thr0 = 2 * P0 + 5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (N0 + 1 + 3) @(negedge clk);
        n_chk++;
        if (bus0.dp_row_a !== exp_row(N0, 1, 1'b0) || bus0.dp_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pkg1 got %h exp %h", bus0.dp_row_a,
                     exp_row(N0, 1, 1'b0));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++;
        if ({bus0.dp_reset, busy0, done0, error0, bus0.mem_rd_en} !== 5'b10000
            || bus0.dp_row_a !== '0 || bus0.dp_row_b !== '0
            || result0 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got rst=%b busy=%b row=%h exp 1/0/0",
                     bus0.dp_reset, busy0, bus0.dp_row_a);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if ({busy0, done0, error0} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_quiet i=%0d got %b exp 000",
                         i, {busy0, done0, error0});
            end
        end
        fill_rand();
        res0 = $urandom;
        thr0 = 2 * P0 + 7;
        run0(1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            res0 = $urandom;
            thr0 = $urandom_range(30, 0);
            run0(1'b0);
        end
    endtask

    // u1: start held high over two runs, no padding expected
    task automatic test_no_pad_start_held();
        int w, s0, d, per, jj;
        logic [4:0]    got, exp;
        logic [RW-1:0] ea, eb;
        fill_rand();
        w    = 4;
        thr1 = 2 * P1 + 3;
        res1 = $urandom;
        s0   = N1 + 1;
        d    = s0 + 2 * P1 + w;
        per  = d + 2;
        start1 = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= per + d + 1; j++) begin
            jj = (j < per) ? j : j - per;
            if (j == per + d) start1 = 1'b0;
            ea = '0;
            eb = '0;
            if (jj >= s0 && jj < s0 + 2 * P1) begin
                ea = exp_row(N1, (jj - s0) / 2, 1'b0);
                eb = exp_row(N1, (jj - s0) / 2, 1'b1);
            end
            exp = {jj < N1, !(jj >= s0 && jj < d), jj == d, 1'b0, jj <= d};
            got = {bus1.mem_rd_en, bus1.dp_reset, done1, error1, busy1};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL held_ctl j=%0d got %b exp %b", j, got, exp);
            end
            n_chk++;
            if (bus1.dp_row_a !== ea || bus1.dp_row_b !== eb) begin
                n_fail++;
                $display("FAIL held_rows j=%0d got %h exp %h", j,
                         bus1.dp_row_a, ea);
            end
            if (jj == s0 || jj == s0 + 2) begin
                for (int s = 0; s < NI; s++) begin
                    n_chk++;
                    if (bus1.dp_row_a[RW-1-32*s -: 32] === '0
                        || bus1.dp_row_b[RW-1-32*s -: 32] === '0) begin
                        n_fail++;
                        $display("FAIL nopad_slot j=%0d s=%0d got 0 exp nonzero",
                                 j, s);
                    end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({busy1, bus1.mem_rd_en, done1} !== 3'b000) begin
                n_fail++;
                $display("FAIL held_stop i=%0d got %b exp 000",
                         i, {busy1, bus1.mem_rd_en, done1});
            end
            @(negedge clk);
        end
        n_chk++;
        if (result1 !== res1) begin
            n_fail++;
            $display("FAIL held_result got %h exp %h", result1, res1);
        end
    endtask

    initial begin
        test_reset();
        test_pack_pad();
        test_stream_timing();
        test_result_capture();
        test_timeout();
        test_stale_finish();
        test_reset_mid();
        test_random();
        test_no_pad_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
